// File: rtl/muldiv_pkg.sv
// ============================================================
// muldiv_pkg : shared types and operation decode helpers for the RV32M sequencer
// Rev 1.0
// ============================================================
`default_nettype none

package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } muldiv_state_e;

   localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

   function automatic logic is_signed_a(input muldiv_op_e op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_signed_b(input muldiv_op_e op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_div(input muldiv_op_e op);
      return op[2];
   endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_sequencer_if.sv
// ============================================================
// muldiv_sequencer_if : request/response bundle between EX stage and muldiv sequencer
// Rev 1.0
// ============================================================
`default_nettype none

interface muldiv_sequencer_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      Funct3;
   logic [XLEN-1:0] SrcA;
   logic [XLEN-1:0] SrcB;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, Funct3, SrcA, SrcB, flush,
      input  busy, done, result
   );

   modport slave (
      input  start, Funct3, SrcA, SrcB, flush,
      output busy, done, result
   );
endinterface

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================
// muldiv_sequencer : radix-2 shift-add multiply / restoring divide, XLEN iterations
// Rev 1.0 | define MULDIV_FUSE_EN to add a last-division result cache
// ============================================================
`default_nettype none

module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  wire logic          clk,
   input  wire logic          reset,
   muldiv_sequencer_if.slave  bus
);

   localparam int             CW        = $clog2(XLEN);
   localparam logic [CW-1:0]  LAST_ITER = CW'(XLEN - 1);

   muldiv_state_e       r_state;
   muldiv_state_e       w_state_next;
   muldiv_op_e          r_op;
   muldiv_op_e          w_op;
   logic [CW-1:0]       r_cnt;
   logic [XLEN-1:0]     r_a_mag;
   logic [XLEN-1:0]     r_b_mag;
   logic [2*XLEN-1:0]   r_acc;
   logic                r_sa;
   logic                r_sb;
   logic                r_done;
   logic [XLEN-1:0]     r_result;

   logic                w_sa;
   logic                w_sb;
   logic [XLEN-1:0]     w_a_mag;
   logic [XLEN-1:0]     w_b_mag;
   logic                w_div0;
   logic                w_ovf;
   logic                w_hit;
   logic                w_fast;
   logic [XLEN-1:0]     w_hit_result;
   logic [XLEN-1:0]     w_fast_result;
   logic [XLEN:0]       w_mul_sum;
   logic [2*XLEN-1:0]   w_mul_step;
   logic [XLEN:0]       w_div_diff;
   logic [2*XLEN-1:0]   w_div_step;
   logic [2*XLEN-1:0]   w_prod;
   logic [XLEN-1:0]     w_quot;
   logic [XLEN-1:0]     w_rem;
   logic [XLEN-1:0]     w_fix_result;

   assign w_op    = muldiv_op_e'(bus.Funct3);
   assign w_sa    = is_signed_a(w_op) & bus.SrcA[XLEN-1];
   assign w_sb    = is_signed_b(w_op) & bus.SrcB[XLEN-1];
   assign w_a_mag = w_sa ? -bus.SrcA : bus.SrcA;
   assign w_b_mag = w_sb ? -bus.SrcB : bus.SrcB;

   // Cases with a closed-form answer skip the iteration entirely
   assign w_div0 = is_div(w_op) && (bus.SrcB == '0);
   assign w_ovf  = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                   (bus.SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (bus.SrcB == '1);
   assign w_fast = w_div0 || w_ovf || w_hit;

   always_comb begin
      w_fast_result = w_hit_result;
      if (w_div0)
         w_fast_result = w_op[1] ? bus.SrcA : '1;
      else if (w_ovf)
         w_fast_result = w_op[1] ? '0 : bus.SrcA;
   end

`ifdef MULDIV_FUSE_EN
   logic            r_c_valid;
   logic            r_c_signed;
   logic [XLEN-1:0] r_c_a;
   logic [XLEN-1:0] r_c_b;
   logic [XLEN-1:0] r_c_q;
   logic [XLEN-1:0] r_c_r;
   logic [XLEN-1:0] r_pend_a;
   logic [XLEN-1:0] r_pend_b;

   assign w_hit = is_div(w_op) && r_c_valid && (bus.SrcA == r_c_a) &&
                  (bus.SrcB == r_c_b) && (r_c_signed == is_signed_a(w_op));
   assign w_hit_result = w_op[1] ? r_c_r : r_c_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_c_valid  <= 1'b0;
         r_c_signed <= 1'b0;
         r_c_a      <= '0;
         r_c_b      <= '0;
         r_c_q      <= '0;
         r_c_r      <= '0;
         r_pend_a   <= '0;
         r_pend_b   <= '0;
      end else begin
         if (r_state == IDLE && w_state_next == CALC) begin
            r_pend_a <= bus.SrcA;
            r_pend_b <= bus.SrcB;
         end
         if ((r_state == CALC || r_state == FIX) && bus.flush && is_div(r_op)) begin
            r_c_valid <= 1'b0;
         end else if (r_state == FIX && is_div(r_op)) begin
            r_c_valid  <= 1'b1;
            r_c_signed <= is_signed_a(r_op);
            r_c_a      <= r_pend_a;
            r_c_b      <= r_pend_b;
            r_c_q      <= w_quot;
            r_c_r      <= w_rem;
         end
      end
   end
`else
   assign w_hit        = 1'b0;
   assign w_hit_result = '0;
`endif

   // Multiply: multiplier sits in the low half and shifts out as the product shifts in
   assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_a_mag};
   assign w_mul_step = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};

   // Divide: upper half is the partial remainder, lower half turns from dividend into quotient
   assign w_div_diff = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_b_mag};
   assign w_div_step = w_div_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                        : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

   assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
   assign w_quot = (r_sa ^ r_sb) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
   assign w_rem  = r_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

   always_comb begin
      w_fix_result = w_prod[2*XLEN-1:XLEN];
      case (r_op)
         OP_MUL:          w_fix_result = w_prod[XLEN-1:0];
         OP_DIV, OP_DIVU: w_fix_result = w_quot;
         OP_REM, OP_REMU: w_fix_result = w_rem;
         default:         w_fix_result = w_prod[2*XLEN-1:XLEN];
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE: if (bus.start && !bus.flush) w_state_next = w_fast ? DONE : CALC;
         CALC: begin
            if (bus.flush)               w_state_next = IDLE;
            else if (r_cnt == LAST_ITER) w_state_next = FIX;
         end
         FIX:     w_state_next = bus.flush ? IDLE : DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op     <= OP_MUL;
         r_cnt    <= '0;
         r_a_mag  <= '0;
         r_b_mag  <= '0;
         r_acc    <= '0;
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_done <= (w_state_next == DONE);
         if (w_state_next == DONE)
            r_result <= (r_state == IDLE) ? w_fast_result : w_fix_result;
         case (r_state)
            IDLE: begin
               if (w_state_next == CALC) begin
                  r_op    <= w_op;
                  r_sa    <= w_sa;
                  r_sb    <= w_sb;
                  r_a_mag <= w_a_mag;
                  r_b_mag <= w_b_mag;
                  r_cnt   <= '0;
                  r_acc   <= is_div(w_op) ? {{XLEN{1'b0}}, w_a_mag} : {{XLEN{1'b0}}, w_b_mag};
               end
            end
            CALC: begin
               r_cnt <= r_cnt + CW'(1);
               r_acc <= is_div(r_op) ? w_div_step : w_mul_step;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = (r_state != IDLE);
   assign bus.done   = r_done;
   assign bus.result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================
// tb_muldiv_sequencer : directed self-checking bench for muldiv_sequencer
// Rev 1.0
// ============================================================
`default_nettype none

module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   localparam int XLEN = 32;
`ifdef MULDIV_FUSE_EN
   localparam int REPEAT_LAT = 1;
`else
   localparam int REPEAT_LAT = 34;
`endif

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   muldiv_sequencer_if #(.XLEN(XLEN)) bus ();

   muldiv_sequencer #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Called just after an edge with the DUT idle; lat counts edges from the sampling edge
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
      bus.Funct3 = f3; bus.SrcA = a; bus.SrcB = b; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = 1;
      while (bus.done !== 1'b1 && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      if (bus.done !== 1'b1) lat = -1;
      res = bus.result;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.flush = 1'b0; bus.Funct3 = 3'd0; bus.SrcA = '0; bus.SrcB = '0;
      reset = 1'b1;
      #3;
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      n_tests++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", bus.result); end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_mul();
      int busy_err = 0;
      int done_err = 0;
      bus.Funct3 = OP_MUL; bus.SrcA = 32'd7; bus.SrcB = 32'hFFFFFFFD; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int e = 1; e <= 33; e++) begin
         if (bus.busy !== 1'b1) busy_err++;
         if (bus.done !== 1'b0) done_err++;
         @(posedge clk); #1;
      end
      n_tests++; if (busy_err != 0) begin n_fail++; $display("FAIL mul_busy_window: got %0d low cycles expected 0", busy_err); end
      n_tests++; if (done_err != 0) begin n_fail++; $display("FAIL mul_done_early: got %0d early pulses expected 0", done_err); end
      n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL mul_done_edge34: got %b expected 1", bus.done); end
      n_tests++; if (bus.result !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_result: got %h expected FFFFFFEB", bus.result); end
      @(posedge clk); #1;
      n_tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mul_after_done: got done=%b busy=%b expected 0/0", bus.done, bus.busy); end
   endtask

   task automatic test_mulh();
      logic [31:0] res;
      int lat;
      run_op(OP_MULH, 32'h80000000, 32'h80000000, res, lat);
      n_tests++; if (res !== 32'h40000000 || lat != 34) begin n_fail++; $display("FAIL mulh: got %h lat %0d expected 40000000 lat 34", res, lat); end
      run_op(OP_MULHU, 32'h80000000, 32'h80000000, res, lat);
      n_tests++; if (res !== 32'h40000000 || lat != 34) begin n_fail++; $display("FAIL mulhu: got %h lat %0d expected 40000000 lat 34", res, lat); end
      run_op(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat);
      n_tests++; if (res !== 32'hFFFFFFFF || lat != 34) begin n_fail++; $display("FAIL mulhsu: got %h lat %0d expected FFFFFFFF lat 34", res, lat); end
      run_op(OP_MUL, 32'h12345678, 32'h00000100, res, lat);
      n_tests++; if (res !== 32'h34567800) begin n_fail++; $display("FAIL mul_low: got %h expected 34567800", res); end
   endtask

   task automatic test_div();
      logic [31:0] res;
      int lat;
      run_op(OP_DIVU, 32'd100, 32'd7, res, lat);
      n_tests++; if (res !== 32'd14 || lat != 34) begin n_fail++; $display("FAIL divu: got %h lat %0d expected 0000000e lat 34", res, lat); end
      run_op(OP_REMU, 32'd100, 32'd7, res, lat);
      n_tests++; if (res !== 32'd2 || lat != REPEAT_LAT) begin n_fail++; $display("FAIL remu: got %h lat %0d expected 00000002 lat %0d", res, lat, REPEAT_LAT); end
      run_op(OP_REM, 32'hFFFFFFF9, 32'd2, res, lat);
      n_tests++; if (res !== 32'hFFFFFFFF || lat != 34) begin n_fail++; $display("FAIL rem_neg: got %h lat %0d expected FFFFFFFF lat 34", res, lat); end
      run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, res, lat);
      n_tests++; if (res !== 32'hFFFFFFFD || lat != REPEAT_LAT) begin n_fail++; $display("FAIL div_neg: got %h lat %0d expected FFFFFFFD lat %0d", res, lat, REPEAT_LAT); end
   endtask

   task automatic test_fast_path();
      logic [31:0] res;
      int lat;
      run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, res, lat);
      n_tests++; if (res !== 32'h80000000 || lat != 1) begin n_fail++; $display("FAIL div_ovf: got %h lat %0d expected 80000000 lat 1", res, lat); end
      run_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, res, lat);
      n_tests++; if (res !== 32'h0 || lat != 1) begin n_fail++; $display("FAIL rem_ovf: got %h lat %0d expected 00000000 lat 1", res, lat); end
      run_op(OP_DIVU, 32'd5, 32'd0, res, lat);
      n_tests++; if (res !== 32'hFFFFFFFF || lat != 1) begin n_fail++; $display("FAIL divu_zero: got %h lat %0d expected FFFFFFFF lat 1", res, lat); end
      run_op(OP_REMU, 32'd5, 32'd0, res, lat);
      n_tests++; if (res !== 32'd5 || lat != 1) begin n_fail++; $display("FAIL remu_zero: got %h lat %0d expected 00000005 lat 1", res, lat); end
      run_op(OP_REM, 32'hFFFFFFF9, 32'd0, res, lat);
      n_tests++; if (res !== 32'hFFFFFFF9 || lat != 1) begin n_fail++; $display("FAIL rem_zero: got %h lat %0d expected FFFFFFF9 lat 1", res, lat); end
   endtask

   task automatic test_flush();
      logic [31:0] res;
      int lat;
      int dones = 0;
      run_op(OP_MUL, 32'd3, 32'd5, res, lat);
      n_tests++; if (res !== 32'd15) begin n_fail++; $display("FAIL flush_setup: got %h expected 0000000f", res); end
      bus.Funct3 = OP_MUL; bus.SrcA = 32'h1234; bus.SrcB = 32'h10; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before: got %b expected 1", bus.busy); end
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after: got %b expected 0", bus.busy); end
      repeat (40) begin @(posedge clk); #1; if (bus.done === 1'b1) dones++; end
      n_tests++; if (dones != 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses expected 0", dones); end
      n_tests++; if (bus.result !== 32'd15) begin n_fail++; $display("FAIL flush_result_hold: got %h expected 0000000f", bus.result); end
      bus.start = 1'b1; bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.flush = 1'b0;
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_over_start: got busy %b expected 0", bus.busy); end
   endtask

   task automatic test_start_while_busy();
      int lat = -1;
      int dones = 0;
      bus.Funct3 = OP_MUL; bus.SrcA = 32'd6; bus.SrcB = 32'd7; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      bus.Funct3 = OP_DIVU; bus.SrcA = 32'd5; bus.SrcB = 32'd0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n_tests++; if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.result !== 32'd15) begin
         n_fail++; $display("FAIL busy_start_ignored: got busy=%b done=%b result=%h expected 1/0/0000000f", bus.busy, bus.done, bus.result);
      end
      for (int e = 6; e <= 70; e++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) begin dones++; if (lat < 0) lat = e; end
      end
      n_tests++; if (lat != 34 || dones != 1) begin n_fail++; $display("FAIL busy_done_count: got edge %0d pulses %0d expected edge 34 pulses 1", lat, dones); end
      n_tests++; if (bus.result !== 32'd42) begin n_fail++; $display("FAIL busy_result: got %h expected 0000002a", bus.result); end
   endtask

   task automatic test_reset_mid_op();
      int dones = 0;
      bus.Funct3 = OP_MULHU; bus.SrcA = 32'hFFFFFFFF; bus.SrcB = 32'hFFFFFFFF; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      #2 reset = 1'b1;
      #1;
      n_tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
         n_fail++; $display("FAIL reset_mid_op: got busy=%b done=%b result=%h expected 0/0/00000000", bus.busy, bus.done, bus.result);
      end
      #1 reset = 1'b0;
      @(posedge clk); #1;
      repeat (40) begin @(posedge clk); #1; if (bus.done === 1'b1) dones++; end
      n_tests++; if (dones != 0) begin n_fail++; $display("FAIL reset_mid_no_done: got %0d pulses expected 0", dones); end
   endtask

   task automatic test_div_cache();
      logic [31:0] res;
      int lat;
      run_op(OP_DIV, 32'd100, 32'd7, res, lat);
      n_tests++; if (res !== 32'd14 || lat != 34) begin n_fail++; $display("FAIL cache_div: got %h lat %0d expected 0000000e lat 34", res, lat); end
      run_op(OP_REM, 32'd100, 32'd7, res, lat);
      n_tests++; if (res !== 32'd2 || lat != REPEAT_LAT) begin n_fail++; $display("FAIL cache_rem_hit: got %h lat %0d expected 00000002 lat %0d", res, lat, REPEAT_LAT); end
      run_op(OP_REM, 32'd100, 32'd6, res, lat);
      n_tests++; if (res !== 32'd4 || lat != 34) begin n_fail++; $display("FAIL cache_rem_miss: got %h lat %0d expected 00000004 lat 34", res, lat); end
      bus.Funct3 = OP_DIV; bus.SrcA = 32'd9; bus.SrcB = 32'd3; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      run_op(OP_DIV, 32'd100, 32'd6, res, lat);
      n_tests++; if (res !== 32'd16 || lat != 34) begin n_fail++; $display("FAIL cache_flush_inval: got %h lat %0d expected 00000010 lat 34", res, lat); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mulh();
      test_div();
      test_fast_path();
      test_flush();
      test_start_while_busy();
      test_reset_mid_op();
      test_div_cache();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle sequencer for the RV32M multiply/divide operations, sitting beside the single-cycle ALU in the EX stage. It accepts one operation per start pulse and runs a radix-2 shift-add multiply or restoring divide for XLEN iterations. It asserts busy so the hazard logic stalls IF/ID/EX, then returns the result with a one-cycle done pulse. Operation is selected by the instruction's Funct3 when Funct7 = 0000001.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
Funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcA  input  XLEN  rs1 operand; multiplicand or dividend
SrcB  input  XLEN  rs2 operand; multiplier or divisor
flush  input  1  synchronous abort (branch mispredict/pipeline flush)
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse; result valid this cycle
result  output  XLEN  final value; holds until next done

Behaviour:
- Reset (async): state IDLE; busy=0, done=0, result=0; counter, operand and accumulator registers cleared.
- States:
  - IDLE: start&!flush latches Funct3, SrcA and SrcB, converts signed operands to magnitudes, records result sign, counter=0 -> CALC. Divide-by-zero and signed overflow go -> DONE instead (fast path).
  - CALC: one iteration per cycle; counter increments; after iteration XLEN-1 -> FIX.
  - FIX: applies two's-complement sign correction and selects the high or low product half, or quotient or remainder -> DONE.
  - DONE: done=1, result driven -> IDLE.
- Latency: normal op has done high in the cycle after edge XLEN+2, counted from the start-sampling edge (edge 34 for XLEN=32). Fast path has done after edge 1.
- Multiply: 2*XLEN-bit product.
  - MUL returns the low half; MULH, MULHSU and MULHU return the high half.
  - MULH treats both operands as signed; MULHSU treats A as signed and B as unsigned.
  - Negating a 2*XLEN product must handle -2^(XLEN-1) magnitudes without overflow, using XLEN+1-bit intermediates.
- Divide: restoring algorithm; quotient sign = signA^signB; remainder sign = signA (sign of dividend).
- Divide-by-zero: DIV/DIVU return all ones; REM/REMU return SrcA.
- Overflow: DIV with -2^(XLEN-1) / -1 returns -2^(XLEN-1); REM returns 0.
- start while busy: ignored, with no queueing.
- flush: in any non-IDLE state -> IDLE next edge. busy falls and no done is issued. In IDLE, flush overrides start.
- done and result are registered outputs, not combinational from inputs.
- Reset mid-operation: immediate return to reset values; no done.

Optional Feature:
MULDIV_FUSE_EN: adds a last-division cache holding SrcA, SrcB, signedness, quotient and remainder from the most recent completed DIV/DIVU/REM/REMU.
- With the macro: a division-class start whose operands and signedness match the cache takes the fast path (done after edge 1) and returns the cached quotient or remainder. The cache is invalidated by reset and by flush during a division.
- Without the macro: no cache; every division takes the full latency.

Decomposition:
- Package muldiv_pkg:
  - enum muldiv_op_e for the eight Funct3 codes
  - enum muldiv_state_e {IDLE, CALC, FIX, DONE}
  - localparam MULDIV_FUNCT7 = 7'b0000001
  - helper functions is_signed_a, is_signed_b, is_div
- No sub-module: the iteration datapath is small enough to live inline in the FSM's sequential block.

Test Plan:
- MUL 7 × 0xFFFFFFFD -> result 0xFFFFFFEB; done exactly at edge 34; busy high edges 1-33.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIVU 100 / 7 -> 14; REMU -> 2; REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF; DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0; DIVU 5 / 0 -> 0xFFFFFFFF and REMU -> 5; all of these with done after edge 1.
- Flush asserted at edge 10 of a MUL -> busy 0 after edge 11, no done ever. A start during busy is ignored, and result keeps its prior value.
- With MULDIV_FUSE_EN: DIV 100/7 then REM 100/7 -> second returns 2 with done after edge 1. REM 100/6 -> full latency, result 4.
